// File: rtl/align_ctrl_if.sv
// VLSU AR/R snoop port and aligner control bundle for align_ctrl.
// Statistic outputs exist in every build and read 0 unless ALIGN_CTRL_STATS_EN is defined.
interface align_ctrl_if #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned NumTrackers  = 8
);
  localparam int unsigned NumStages = $clog2(AxiDataWidth / 8);
  localparam int unsigned BeWidth   = AxiDataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(NumTrackers) + 1;

  logic                    ar_valid_i;
  logic [AxiAddrWidth-1:0] ar_addr_i;
  logic [7:0]              ar_len_i;
  logic                    ar_ready_i;
  logic                    ar_ready_o;
  logic                    r_valid_i;
  logic                    r_ready_i;
  logic                    r_last_i;
  logic [NumStages-1:0]    shift_en_o;
  logic [BeWidth-1:0]      be_o;
  logic                    first_o;
  logic                    last_o;
  logic                    flush_o;
  logic                    cfg_valid_o;
  logic                    err_o;
  logic [CntWidth-1:0]     cnt_o;
  logic [31:0]             stat_bursts_o;
  logic [31:0]             stat_unaligned_o;

  modport master (
    output ar_valid_i, ar_addr_i, ar_len_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i,
    input  ar_ready_o, shift_en_o, be_o, first_o, last_o, flush_o, cfg_valid_o, err_o, cnt_o,
           stat_bursts_o, stat_unaligned_o
  );

  modport slave (
    input  ar_valid_i, ar_addr_i, ar_len_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i,
    output ar_ready_o, shift_en_o, be_o, first_o, last_o, flush_o, cfg_valid_o, err_o, cnt_o,
           stat_bursts_o, stat_unaligned_o
  );
endinterface

// File: rtl/align_ctrl.sv
// Read-alignment scheduler: tracks AR bursts in a descriptor FIFO and drives per-beat aligner controls.
// Optional burst statistics counters are built when ALIGN_CTRL_STATS_EN is defined.
module align_ctrl #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned NumTrackers  = 8
) (
  input logic        clk_i,
  input logic        rst_i,
  align_ctrl_if.slave bus
);
  localparam int unsigned NumStages = $clog2(AxiDataWidth / 8);
  localparam int unsigned BeWidth   = AxiDataWidth / 8;
  localparam int unsigned PtrWidth  = $clog2(NumTrackers);
  localparam int unsigned CntWidth  = $clog2(NumTrackers) + 1;

  logic [NumStages-1:0] r_off_mem [NumTrackers];
  logic [7:0]           r_len_mem [NumTrackers];
  logic [PtrWidth-1:0]  r_wr_ptr;
  logic [PtrWidth-1:0]  r_rd_ptr;
  logic [CntWidth-1:0]  r_cnt;
  logic [7:0]           r_beat_cnt;
  logic                 r_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_ar_ready;
  logic                 w_push;
  logic                 w_hs;
  logic                 w_at_len;
  logic                 w_pop;
  logic [NumStages-1:0] w_head_off;
  logic [7:0]           w_head_len;
  logic                 w_unused;

  // Only the in-beat byte offset of the address matters to the aligner.
  assign w_unused = ^bus.ar_addr_i[AxiAddrWidth-1:NumStages];

  assign w_full     = (r_cnt == CntWidth'(NumTrackers));
  assign w_empty    = (r_cnt == '0);
  assign w_ar_ready = bus.ar_ready_i && !w_full;
  assign w_push     = bus.ar_valid_i && w_ar_ready;
  assign w_hs       = bus.r_valid_i && bus.r_ready_i;
  assign w_head_off = r_off_mem[r_rd_ptr];
  assign w_head_len = r_len_mem[r_rd_ptr];
  assign w_at_len   = (r_beat_cnt == w_head_len);
  assign w_pop      = w_hs && !w_empty && w_at_len;

  assign bus.ar_ready_o = w_ar_ready;

  // Descriptor storage; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_off_mem[r_wr_ptr] <= bus.ar_addr_i[NumStages-1:0];
      r_len_mem[r_wr_ptr] <= bus.ar_len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase
      // Sequencing follows the descriptor length; r_last_i only feeds the checker.
      if (w_hs && !w_empty) r_beat_cnt <= w_at_len ? 8'd0 : r_beat_cnt + 8'd1;
      if (w_hs && (w_empty || (bus.r_last_i != w_at_len))) r_err <= 1'b1;
    end
  end

  // Head-of-queue controls, forced to zero while no descriptor is present.
  always_comb begin
    bus.cfg_valid_o = 1'b0;
    bus.first_o     = 1'b0;
    bus.last_o      = 1'b0;
    bus.flush_o     = 1'b0;
    bus.shift_en_o  = '0;
    bus.be_o        = '0;
    if (!w_empty) begin
      bus.cfg_valid_o = 1'b1;
      bus.first_o     = (r_beat_cnt == 8'd0);
      bus.last_o      = w_at_len;
      bus.flush_o     = (w_head_off != '0);
      bus.shift_en_o  = w_head_off;
      bus.be_o        = (r_beat_cnt == 8'd0) ? BeWidth'({BeWidth{1'b1}} << w_head_off)
                                             : {BeWidth{1'b1}};
    end
  end

  assign bus.err_o = r_err;
  assign bus.cnt_o = r_cnt;

`ifdef ALIGN_CTRL_STATS_EN
  logic [31:0] r_stat_bursts;
  logic [31:0] r_stat_unaligned;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_bursts    <= '0;
      r_stat_unaligned <= '0;
    end else if (w_pop) begin
      r_stat_bursts <= r_stat_bursts + 32'd1;
      if (w_head_off != '0) r_stat_unaligned <= r_stat_unaligned + 32'd1;
    end
  end

  assign bus.stat_bursts_o    = r_stat_bursts;
  assign bus.stat_unaligned_o = r_stat_unaligned;
`else
  assign bus.stat_bursts_o    = '0;
  assign bus.stat_unaligned_o = '0;
`endif

endmodule

// File: tb/tb_align_ctrl.sv
// Directed bench for align_ctrl: a descriptor model feeds a per-beat scoreboard of expected controls.
module tb_align_ctrl;
  localparam int unsigned NT = 8;

  typedef struct packed {
    logic [2:0] off;
    logic [7:0] len;
  } desc_t;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] be;
    logic [2:0] sh;
    logic       fl;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  desc_t       desc_q[$];
  exp_t        exp_q[$];
  logic [7:0]  m_beat;
  logic        m_err;
  logic [31:0] m_bursts;
  logic [31:0] m_unal;

  align_ctrl_if #(.AxiDataWidth(64), .AxiAddrWidth(64), .NumTrackers(NT)) bus ();

  align_ctrl #(.AxiDataWidth(64), .AxiAddrWidth(64), .NumTrackers(NT)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef ALIGN_CTRL_STATS_EN
    chk("stat_bursts", bus.stat_bursts_o, m_bursts);
    chk("stat_unaligned", bus.stat_unaligned_o, m_unal);
`else
    chk("stat_bursts_tied", bus.stat_bursts_o, 32'd0);
    chk("stat_unaligned_tied", bus.stat_unaligned_o, 32'd0);
`endif
  endtask

  // One clock of stimulus; starts and ends mid-cycle, checks before and after the edge.
  task automatic cyc(input logic av, input logic [63:0] addr, input logic [7:0] len,
                     input logic rv, input logic rl);
    exp_t  e;
    desc_t d;
    logic  exp_rdy;
    bus.ar_valid_i = av;
    bus.ar_addr_i  = addr;
    bus.ar_len_i   = len;
    bus.r_valid_i  = rv;
    bus.r_ready_i  = 1'b1;
    bus.r_last_i   = rl;
    #1;
    exp_rdy = bus.ar_ready_i && (desc_q.size() != NT);
    chk("ar_ready", 32'(bus.ar_ready_o), 32'(exp_rdy));
    chk("cfg_valid", 32'(bus.cfg_valid_o), 32'(desc_q.size() != 0));
    if (rv && desc_q.size() != 0) begin
      d       = desc_q[0];
      e.first = (m_beat == 8'd0);
      e.last  = (m_beat == d.len);
      e.be    = (m_beat == 8'd0) ? 8'(8'hFF << d.off) : 8'hFF;
      e.sh    = d.off;
      e.fl    = (d.off != 3'd0);
      exp_q.push_back(e);
    end else if (desc_q.size() == 0) begin
      chk("idle_be", 32'(bus.be_o), 32'd0);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("beat_ctl", 32'({bus.first_o, bus.last_o, bus.be_o, bus.shift_en_o, bus.flush_o}),
          32'(e));
    end
    @(posedge clk);
    if (rv) begin
      if (desc_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        d = desc_q[0];
        if (rl != (m_beat == d.len)) m_err = 1'b1;
        if (m_beat == d.len) begin
          void'(desc_q.pop_front());
          m_beat   = 8'd0;
          m_bursts = m_bursts + 32'd1;
          if (d.off != 3'd0) m_unal = m_unal + 32'd1;
        end else begin
          m_beat = m_beat + 8'd1;
        end
      end
    end
    if (av && exp_rdy) desc_q.push_back('{off: addr[2:0], len: len});
    #2;
    chk("cnt", 32'(bus.cnt_o), 32'(desc_q.size()));
    chk("err", 32'(bus.err_o), 32'(m_err));
    bus.ar_valid_i = 1'b0;
    bus.r_valid_i  = 1'b0;
    bus.r_last_i   = 1'b0;
  endtask

  task automatic rbeat();
    logic rl;
    rl = (desc_q.size() != 0) && (m_beat == desc_q[0].len);
    cyc(1'b0, 64'd0, 8'd0, 1'b1, rl);
  endtask

  task automatic idle();
    cyc(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_cfg_valid", 32'(bus.cfg_valid_o), 32'd0);
    chk("rst_cnt", 32'(bus.cnt_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_first_last", 32'({bus.first_o, bus.last_o, bus.flush_o}), 32'd0);
    desc_q.delete();
    exp_q.delete();
    m_beat   = 8'd0;
    m_err    = 1'b0;
    m_bursts = 32'd0;
    m_unal   = 32'd0;
    chk_stats();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_beat = 8'd0;
    m_err = 1'b0;
    m_bursts = 32'd0;
    m_unal = 32'd0;
    rst = 1'b1;
    bus.ar_valid_i = 1'b0;
    bus.ar_addr_i  = 64'd0;
    bus.ar_len_i   = 8'd0;
    bus.ar_ready_i = 1'b0;
    bus.r_valid_i  = 1'b0;
    bus.r_ready_i  = 1'b0;
    bus.r_last_i   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ar_ready_lo", 32'(bus.ar_ready_o), 32'd0);
    chk("rst_outputs", 32'({bus.cfg_valid_o, bus.first_o, bus.last_o, bus.flush_o,
                            bus.err_o, bus.be_o, bus.shift_en_o}), 32'd0);
    chk("rst_cnt0", 32'(bus.cnt_o), 32'd0);
    bus.ar_ready_i = 1'b1;
    #1;
    chk("rst_ar_ready_hi", 32'(bus.ar_ready_o), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Aligned burst, 4 beats
    cyc(1'b1, 64'h1000, 8'd3, 1'b0, 1'b0);
    repeat (4) rbeat();

    // Unaligned burst, offset 5
    cyc(1'b1, 64'h1005, 8'd1, 1'b0, 1'b0);
    repeat (2) rbeat();
    chk_stats();

    // Fill the tracker, then a pop while full must not admit the pending push
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'(i * 9), 8'(i % 2), 1'b0, 1'b0);
    chk("full_cnt", 32'(bus.cnt_o), 32'd8);
    cyc(1'b1, 64'h2000, 8'd0, 1'b1, 1'b1);
    chk("after_full_pop", 32'(bus.cnt_o), 32'd7);
    for (int k = 0; k < 32 && desc_q.size() != 0; k++) rbeat();
    chk("drained", 32'(bus.cnt_o), 32'd0);

    // Downstream not ready blocks acceptance
    bus.ar_ready_i = 1'b0;
    cyc(1'b1, 64'h2100, 8'd0, 1'b0, 1'b0);
    bus.ar_ready_i = 1'b1;

    // 20 back-to-back single-beat bursts with overlapped push/pop
    cyc(1'b1, 64'h0, 8'd0, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) cyc(1'b1, 64'(k * 3), 8'd0, 1'b1, 1'b1);
    rbeat();
    chk_stats();

    // Early r_last on beat 2 of a 4-beat burst
    cyc(1'b1, 64'h3000, 8'd3, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 8'd0, 1'b1, 1'b1);
    idle();

    // Handshake on an empty tracker
    do_reset();
    cyc(1'b0, 64'd0, 8'd0, 1'b1, 1'b1);
    idle();

    // Push into an empty tracker alongside an R handshake
    do_reset();
    cyc(1'b1, 64'h4000, 8'd0, 1'b1, 1'b1);
    rbeat();

    // Reset in the middle of a 6-beat burst, then a fresh burst
    do_reset();
    cyc(1'b1, 64'h5000, 8'd5, 1'b0, 1'b0);
    repeat (2) rbeat();
    do_reset();
    cyc(1'b1, 64'h5003, 8'd2, 1'b0, 1'b0);
    repeat (3) rbeat();
    idle();
    chk_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
